nibble_uart_tx: RTL and testbench

//  Downstream consumer of the 4-bit free-running counter value. Detects each

---
 rtl/nibble_uart_tx.sv | 157 +++++++++++++++
 tb/tb_nibble_uart_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_uart_tx.sv
// Sends each new 4-bit counter value as an ASCII hex character on a UART 8N1 line.
// Build option NIBBLE_UART_TX_CRLF_EN appends CR/LF frames after every character.
module nibble_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic [3:0] i_Data,
    output logic       o_Tx,
    output logic       o_Busy,
    output logic       o_Overrun
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef NIBBLE_UART_TX_CRLF_EN
    typedef enum logic [1:0] {SEQ_HEX, SEQ_CR, SEQ_LF} seq_t;
    seq_t seq, seq_d;
`endif

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic [3:0]       r_Sample, r_PendVal;
    logic             r_Pend, r_Armed;
    logic             change, consume, bit_end, tx_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // r_Armed is low only for the first cycle after reset: that cycle forces a
    // capture so the value present at release is what gets sent first.
    assign change  = r_Armed && (i_Data != r_Sample);
    assign consume = r_Armed && r_Pend && (state == IDLE);
    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Sample  <= 4'h0;
            r_PendVal <= 4'h0;
            r_Pend    <= 1'b1;
            r_Armed   <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            r_Sample  <= i_Data;
            r_Armed   <= 1'b1;
            o_Overrun <= 1'b0;
            if (!r_Armed) begin
                r_PendVal <= i_Data;
                r_Pend    <= 1'b1;
            end else if (change) begin
                r_PendVal <= i_Data;
                r_Pend    <= 1'b1;
                o_Overrun <= r_Pend && !consume;
            end else if (consume) begin
                r_Pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
`ifdef NIBBLE_UART_TX_CRLF_EN
        seq_d     = seq;
`endif
        case (state)
            IDLE: begin
                if (consume) begin
                    shift_d = hex_ascii(r_PendVal);
                    cnt_d   = '0;
                    state_d = START;
`ifdef NIBBLE_UART_TX_CRLF_EN
                    seq_d   = SEQ_HEX;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
`ifdef NIBBLE_UART_TX_CRLF_EN
                    // Terminator frames chain straight into START so o_Busy never drops.
                    case (seq)
                        SEQ_HEX: begin shift_d = 8'h0D; seq_d = SEQ_CR; state_d = START; end
                        SEQ_CR:  begin shift_d = 8'h0A; seq_d = SEQ_LF; state_d = START; end
                        default: state_d = IDLE;
                    endcase
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so o_Tx is glitch-free.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            o_Tx    <= 1'b1;
            o_Busy  <= 1'b0;
`ifdef NIBBLE_UART_TX_CRLF_EN
            seq     <= SEQ_HEX;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            o_Tx    <= tx_d;
            o_Busy  <= (state_d != IDLE);
`ifdef NIBBLE_UART_TX_CRLF_EN
            seq     <= seq_d;
`endif
        end
    end
endmodule

// File: tb/tb_nibble_uart_tx.sv
// Scoreboard bench for nibble_uart_tx: stimulus queues expected bytes, a UART
// receiver process decodes o_Tx frames and compares them against the queue.
module tb_nibble_uart_tx;
    localparam int C = 4;
`ifdef NIBBLE_UART_TX_CRLF_EN
    localparam int FRAMES = 3;
`else
    localparam int FRAMES = 1;
`endif
    localparam int BUSY_LEN = 10 * C * FRAMES;

    logic       i_Clock = 1'b0;
    logic       i_Reset_n = 1'b0;
    logic [3:0] i_Data = 4'h0;
    logic       o_Tx, o_Busy, o_Overrun;

    int  checks = 0;
    int  failures = 0;
    int  ovr_cnt = 0;
    byte exp_q[$];

    nibble_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Data    (i_Data),
        .o_Tx      (o_Tx),
        .o_Busy    (o_Busy),
        .o_Overrun (o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_char(input byte c);
        exp_q.push_back(c);
`ifdef NIBBLE_UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_Busy) && t < 3000) begin
            cyc(1);
            t++;
        end
        check(name, (t < 3000) ? 1 : 0, 1);
        cyc(2);
    endtask

    task automatic wait_fall(input string name);
        int t;
        t = 0;
        while (o_Tx && t < 200) begin
            cyc(1);
            t++;
        end
        check(name, (t < 200) ? 1 : 0, 1);
    endtask

    // Receiver: samples mid-bit on the falling clock edge, abandons on reset.
    initial begin
        int  mcnt, brun, k;
        bit  act, busy_prev;
        byte b, e;
        act = 0; mcnt = 0; brun = 0; busy_prev = 0; b = 0;
        forever begin
            @(negedge i_Clock);
            if (o_Overrun) ovr_cnt++;
            if (!i_Reset_n) begin
                act = 0; brun = 0; busy_prev = 0;
            end else begin
                if (o_Busy) brun++;
                else begin
                    if (busy_prev) check("busy_len", brun, BUSY_LEN);
                    brun = 0;
                end
                busy_prev = o_Busy;
                if (!act && !o_Tx) begin
                    act = 1; mcnt = 0;
                end
                if (act) begin
                    if (mcnt % C == C / 2) begin
                        k = mcnt / C;
                        if (k == 0) check("start_bit", int'(o_Tx), 0);
                        else if (k <= 8) b[k-1] = o_Tx;
                        else begin
                            check("stop_bit", int'(o_Tx), 1);
                            if (exp_q.size() == 0) begin
                                check("unexpected_frame", int'(b), -1);
                            end else begin
                                e = exp_q.pop_front();
                                check("frame_byte", int'(b), int'(e));
                            end
                            act = 0;
                        end
                    end
                    mcnt++;
                end
            end
        end
    end

    initial begin
        int ov0;
        // 1: value present during reset is sent once after release
        i_Reset_n = 0; i_Data = 4'h5;
        cyc(3);
        check("rst_tx", int'(o_Tx), 1);
        check("rst_busy", int'(o_Busy), 0);
        check("rst_overrun", int'(o_Overrun), 0);
        i_Reset_n = 1;
        push_char(8'h35);
        cyc(1);
        check("rel_tx_hi", int'(o_Tx), 1);
        cyc(1);
        check("rel_tx_lo", int'(o_Tx), 0);
        wait_idle("idle_t1");
        check("t1_no_overrun", ovr_cnt, 0);

        // 2: 9 -> A, two-cycle latency from change to start bit
        i_Data = 4'h9; push_char(8'h39);
        wait_idle("idle_t2a");
        i_Data = 4'hA; push_char(8'h41);
        cyc(1);
        check("lat_tx_hi", int'(o_Tx), 1);
        cyc(1);
        check("lat_tx_lo", int'(o_Tx), 0);
        check("lat_busy", int'(o_Busy), 1);
        wait_idle("idle_t2b");

        // 3: 1 -> 2 -> 3 inside one frame; '2' overwritten
        ov0 = ovr_cnt;
        i_Data = 4'h1; push_char(8'h31);
        cyc(10);
        i_Data = 4'h2;
        cyc(5);
        i_Data = 4'h3; push_char(8'h33);
        cyc(3);
        check("overrun_pulse", ovr_cnt - ov0, 1);
        wait_idle("idle_t3");
        check("overrun_total", ovr_cnt - ov0, 1);

        // 5: F -> 0 wrap, back-to-back frames
        i_Data = 4'hF; push_char(8'h46);
        cyc(3);
        i_Data = 4'h0; push_char(8'h30);
        wait_idle("idle_t5");

        // 4: reset 15 cycles into a frame
        i_Data = 4'h6; push_char(8'h36);
        wait_fall("fall_t4");
        cyc(14);
        #2 i_Reset_n = 0;
        #1;
        check("midrst_tx", int'(o_Tx), 1);
        check("midrst_busy", int'(o_Busy), 0);
        exp_q.delete();
        cyc(3);
        i_Reset_n = 1;
        push_char(8'h36);
        wait_idle("idle_t4");

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
